pingpong_frame_buffer: RTL and testbench
========================================

// Module: pingpong_frame_buffer
// PURPOSE
//  Double-buffered (ping-pong) cell-state frame memory for the automaton datapath.
//  The generation engine writes the next generation into the BACK bank while the
//  display scanner reads the current generation from the FRONT bank. A swap
//  handshake exchanges the banks at a generation boundary. A hardware clear
//  sequencer zeroes the back bank.
// PARAMETERS
//  DATA_W  32  row width in bits (one bit per cell)
//  DEPTH   75  rows per bank; legal addresses 0..DEPTH-1
//  ADDR_W  7   address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  rst_n       in   1       asynchronous, active-low reset
//  wr_en       in   1       write strobe into back bank
//  wr_addr     in   ADDR_W  write row address
//  wr_data     in   DATA_W  write row data
//  rd_en       in   1       read strobe from front bank
//  rd_addr     in   ADDR_W  read row address
//  rd_data     out  DATA_W  registered read data
//  rd_valid    out  1       rd_data holds the result of a read issued last cycle
//  swap_req    in   1       single-cycle pulse: request bank exchange
//  swap_ack    out  1       single-cycle pulse when the exchange takes effect
//  front_sel   out  1       index of the current front bank (0 or 1)
//  clear_req   in   1       single-cycle pulse: zero every row of the back bank
//  clear_busy  out  1       high while the clear sequence runs
// BEHAVIOUR
//  Reset (rst_n low, async): front_sel=0, rd_data=0, rd_valid=0, swap_ack=0,
//   clear_busy=0, swap-pending flag=0, FSM=IDLE, clear counter=0.
//   RAM contents are not reset.
//  Reads: 1-cycle latency. When rd_en=1 in cycle N:
//   - rd_data = front[rd_addr] in cycle N+1, with rd_valid=1.
//   - If rd_addr >= DEPTH, rd_data=0 (rd_valid still 1).
//   When rd_en=0, rd_data holds its value and rd_valid=0.
//  Writes: when wr_en=1, wr_data is written to back[wr_addr] at the clock edge.
//   - Dropped if wr_addr >= DEPTH.
//   - Dropped while clear_busy=1.
//  Bank selection for reads and writes in a cycle uses the front_sel value
//   present before that cycle's edge. A read or write coincident with the
//   swap edge therefore uses the pre-swap banks.
//  FSM states: IDLE, CLEAR.
//  IDLE:
//   - clear_req=1 -> CLEAR, counter=0, clear_busy=1 from the next cycle.
//   - Otherwise, if swap_req=1 or the pending flag is set: toggle front_sel,
//     pulse swap_ack for one cycle, clear the pending flag.
//   - swap_req and clear_req in the same IDLE cycle: clear wins; the swap is
//     latched as pending.
//  CLEAR:
//   - Each cycle write 0 to back[counter], counter++.
//   - After writing row DEPTH-1, return to IDLE; clear_busy drops the cycle
//     after the last write. Total busy time = DEPTH cycles.
//   - swap_req during CLEAR sets the pending flag. The swap executes in the
//     first IDLE cycle, so swap_ack is asserted 1 cycle after clear_busy falls.
//   - clear_req during CLEAR is ignored (no restart).
//   - Reads from the front bank continue normally during CLEAR.
//  Multiple swap_req pulses while pending collapse into one swap.
//  Reset asserted mid-clear aborts it. Rows not yet cleared keep stale data.
//   After reset, front_sel=0.
// TESTING
//  1 Reset, write 0xA5A5A5A5 to row 3, swap_req -> swap_ack next cycle,
//    front_sel=1; rd_en row 3 -> rd_data=0xA5A5A5A5, rd_valid=1 one cycle later.
//  2 Write row 74 =0xFFFFFFFF and row 75 (out of range); swap; read 74 ->
//    0xFFFFFFFF; read 75 -> 0x00000000; read 127 -> 0; no aliasing into row 0..74.
//  3 Fill back bank with ones, clear_req -> clear_busy high exactly 75 cycles;
//    wr_en during clear ignored; after swap every row reads 0.
//  4 swap_req at cycle 10 of a clear -> no swap_ack until clear ends; swap_ack
//    1 cycle after clear_busy falls; front_sel toggles once only (3 extra pulses).
//  5 Same-cycle read and swap: read row 5 on the swap edge returns old front
//    data; same-cycle write lands in old back (now front) bank.
//  6 Assert rst_n low mid-clear (row 40) and mid-read -> all outputs 0
//    immediately (async); clear_busy=0; front_sel=0.

Source files
------------

// File: rtl/pingpong_frame_buffer.sv
// ---------------------------------------------------------------------------
// pingpong_frame_buffer
//
// Double-buffered cell-state frame memory. The generation engine writes the
// next generation into the back bank while the display scanner reads the
// current generation from the front bank. A swap exchanges the two banks at a
// generation boundary; a clear sequencer zeroes the back bank one row per
// cycle.
//
// Ports
//   clk         in   1       single clock, all logic on posedge
//   rst_n       in   1       asynchronous active-low reset
//   wr_en       in   1       write strobe into the back bank
//   wr_addr     in   ADDR_W  write row address
//   wr_data     in   DATA_W  write row data
//   rd_en       in   1       read strobe from the front bank
//   rd_addr     in   ADDR_W  read row address
//   rd_data     out  DATA_W  registered read data (0 for out-of-range rows)
//   rd_valid    out  1       rd_data holds the read issued last cycle
//   swap_req    in   1       pulse: request a bank exchange
//   swap_ack    out  1       pulse: the exchange took effect on this edge
//   front_sel   out  1       index of the current front bank
//   clear_req   in   1       pulse: zero every row of the back bank
//   clear_busy  out  1       high while the clear sequence runs
//
// Handshake: swap_req/clear_req are one-cycle requests. A swap requested
// while a clear runs (or in the same cycle a clear starts) is held pending
// and performed in the first idle cycle; any number of requests collapse
// into a single exchange. swap_ack pulses for the cycle after the edge on
// which front_sel toggled.
// ---------------------------------------------------------------------------
module pingpong_frame_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 75,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              swap_req,
    output logic              swap_ack,
    output logic              front_sel,
    input  logic              clear_req,
    output logic              clear_busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              swap_pending;

    // Bank storage: no reset, contents survive rst_n.
    logic [DATA_W-1:0] bank0 [DEPTH];
    logic [DATA_W-1:0] bank1 [DEPTH];

    logic              clearing;
    logic              wr_ok;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] front_row;

    assign clearing   = (state == ST_CLEAR);
    assign clear_busy = clearing;

    // The clear sequencer owns the back-bank write port while it runs, so
    // user writes are simply dropped during that window.
    always_comb begin
        wr_ok     = wr_en && !clearing && (wr_addr <= LAST_ROW);
        mem_we    = clearing || wr_ok;
        mem_addr  = clearing ? clr_cnt : wr_addr;
        mem_wdata = clearing ? '0 : wr_data;
    end

    // Back bank is the one not selected by front_sel. front_sel is the
    // pre-edge value, so an access coincident with a swap uses the old banks.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (front_sel) begin
                bank0[mem_addr] <= mem_wdata;
            end else begin
                bank1[mem_addr] <= mem_wdata;
            end
        end
    end

    always_comb begin
        front_row = '0;
        if (rd_addr <= LAST_ROW) begin
            front_row = front_sel ? bank1[rd_addr] : bank0[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= front_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            clr_cnt      <= '0;
            swap_pending <= 1'b0;
            front_sel    <= 1'b0;
            swap_ack     <= 1'b0;
        end else begin
            swap_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        // Clear wins over a simultaneous swap; the swap waits.
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        if (swap_req) begin
                            swap_pending <= 1'b1;
                        end
                    end else if (swap_req || swap_pending) begin
                        front_sel    <= ~front_sel;
                        swap_ack     <= 1'b1;
                        swap_pending <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (swap_req) begin
                        swap_pending <= 1'b1;
                    end
                    if (clr_cnt == LAST_ROW) begin
                        state   <= ST_IDLE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    clr_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_frame_buffer.sv
module tb_pingpong_frame_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 75;
    localparam int ADDR_W = 7;

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_SWAP = 2'd1;
    localparam logic [1:0] OP_RD   = 2'd2;

    typedef struct {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_data;
        logic              exp_front;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_data = '0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              swap_req = 1'b0;
    logic              swap_ack;
    logic              front_sel;
    logic              clear_req = 1'b0;
    logic              clear_busy;

    logic [DATA_W-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    vec_t vecs[16];

    pingpong_frame_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .front_sel  (front_sel),
        .clear_req  (clear_req),
        .clear_busy (clear_busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic issue_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        rd_en   = 1'b1;
        rd_addr = a;
        exp_q.push_back(e);
        step();
        rd_en   = 1'b0;
    endtask

    task automatic do_swap(input logic exp_front);
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        check("swap_ack_pulse", {31'd0, swap_ack}, 32'd1);
        check("front_sel_after_swap", {31'd0, front_sel}, {31'd0, exp_front});
        step();
        check("swap_ack_drop", {31'd0, swap_ack}, 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    initial begin
        logic [DATA_W-1:0] e;
        forever begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_unexpected: got rd_valid=1 data=%h expected no read", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd_data, e);
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int  busy;
        bit  ack_seen;
        bit  front_moved;
        logic f0;

        // directed table: basic write/swap/read plus address boundaries
        vecs[0]  = '{OP_WR,   7'd3,   32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[1]  = '{OP_SWAP, 7'd0,   32'h0,        32'h0,        1'b1};
        vecs[2]  = '{OP_RD,   7'd3,   32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[3]  = '{OP_WR,   7'd74,  32'hFFFFFFFF, 32'h0,        1'b0};
        vecs[4]  = '{OP_WR,   7'd0,   32'h11111111, 32'h0,        1'b0};
        vecs[5]  = '{OP_WR,   7'd11,  32'h22222222, 32'h0,        1'b0};
        vecs[6]  = '{OP_WR,   7'd63,  32'h33333333, 32'h0,        1'b0};
        vecs[7]  = '{OP_WR,   7'd75,  32'hDEADBEEF, 32'h0,        1'b0};
        vecs[8]  = '{OP_WR,   7'd127, 32'hCAFEF00D, 32'h0,        1'b0};
        vecs[9]  = '{OP_SWAP, 7'd0,   32'h0,        32'h0,        1'b0};
        vecs[10] = '{OP_RD,   7'd74,  32'h0,        32'hFFFFFFFF, 1'b0};
        vecs[11] = '{OP_RD,   7'd75,  32'h0,        32'h00000000, 1'b0};
        vecs[12] = '{OP_RD,   7'd127, 32'h0,        32'h00000000, 1'b0};
        vecs[13] = '{OP_RD,   7'd0,   32'h0,        32'h11111111, 1'b0};
        vecs[14] = '{OP_RD,   7'd11,  32'h0,        32'h22222222, 1'b0};
        vecs[15] = '{OP_RD,   7'd63,  32'h0,        32'h33333333, 1'b0};

        // reset: asserted between clock edges, outputs must clear at once
        #1 rst_n = 1'b0;
        #2;
        check("reset_rd_data",    rd_data, 32'd0);
        check("reset_rd_valid",   {31'd0, rd_valid}, 32'd0);
        check("reset_swap_ack",   {31'd0, swap_ack}, 32'd0);
        check("reset_clear_busy", {31'd0, clear_busy}, 32'd0);
        check("reset_front_sel",  {31'd0, front_sel}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // tests 1-2: table driven
        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:   do_write(vecs[i].addr, vecs[i].data);
                OP_SWAP: do_swap(vecs[i].exp_front);
                default: issue_read(vecs[i].addr, vecs[i].exp_data);
            endcase
        end
        step();

        // test 3: fill back bank (bank1) with ones, clear it, writes ignored
        for (int r = 0; r < DEPTH; r++) begin
            do_write(ADDR_W'(r), 32'hFFFFFFFF);
        end
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busy = 0;
        while (clear_busy && busy < 200) begin
            busy++;
            wr_en   = 1'b1;
            wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data = $urandom;
            step();
        end
        wr_en = 1'b0;
        check("clear_busy_cycles", busy, 32'd75);
        do_swap(1'b1);
        for (int r = 0; r < DEPTH; r++) begin
            issue_read(ADDR_W'(r), 32'h0);
        end
        step();

        // test 4: swap requests during clear collapse into one deferred swap
        f0 = front_sel;
        ack_seen = 1'b0;
        front_moved = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        busy = 0;
        while (clear_busy && busy < 200) begin
            busy++;
            swap_req  = (busy == 10 || busy == 20 || busy == 30 || busy == 40);
            clear_req = (busy == 50);
            step();
            if (swap_ack) ack_seen = 1'b1;
            if (front_sel != f0) front_moved = 1'b1;
        end
        swap_req  = 1'b0;
        clear_req = 1'b0;
        check("clear_busy_cycles_no_restart", busy, 32'd75);
        check("no_ack_during_clear", {31'd0, ack_seen}, 32'd0);
        check("no_front_move_during_clear", {31'd0, front_moved}, 32'd0);
        check("ack_not_on_busy_fall", {31'd0, swap_ack}, 32'd0);
        step();
        check("deferred_swap_ack", {31'd0, swap_ack}, 32'd1);
        check("deferred_front_sel", {31'd0, front_sel}, {31'd0, ~f0});
        step();
        check("deferred_ack_single", {31'd0, swap_ack}, 32'd0);
        check("front_sel_toggled_once", {31'd0, front_sel}, {31'd0, ~f0});
        issue_read(7'd74, 32'h0);
        step();

        // test 5: read/write coincident with the swap edge use pre-swap banks
        do_write(7'd5, 32'h55555555);
        rd_en    = 1'b1;
        rd_addr  = 7'd5;
        exp_q.push_back(32'h0);
        swap_req = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = 7'd6;
        wr_data  = 32'h66666666;
        step();
        rd_en    = 1'b0;
        swap_req = 1'b0;
        wr_en    = 1'b0;
        check("coincident_swap_ack", {31'd0, swap_ack}, 32'd1);
        check("coincident_front_sel", {31'd0, front_sel}, 32'd1);
        step();
        issue_read(7'd6, 32'h66666666);
        issue_read(7'd5, 32'h55555555);
        step();

        // test 6: reset in the middle of a clear and a read
        do_write(7'd70, 32'h70707070);
        do_write(7'd2,  32'h02020202);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
        end
        rd_en   = 1'b1;
        rd_addr = 7'd6;
        exp_q.push_back(32'h66666666);
        step();
        @(negedge clk);
        #1;
        check("pre_reset_busy", {31'd0, clear_busy}, 32'd1);
        check("pre_reset_rd_valid", {31'd0, rd_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midclear_rst_rd_data",    rd_data, 32'd0);
        check("midclear_rst_rd_valid",   {31'd0, rd_valid}, 32'd0);
        check("midclear_rst_swap_ack",   {31'd0, swap_ack}, 32'd0);
        check("midclear_rst_clear_busy", {31'd0, clear_busy}, 32'd0);
        check("midclear_rst_front_sel",  {31'd0, front_sel}, 32'd0);
        rd_en = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_reset_idle", {31'd0, clear_busy}, 32'd0);
        issue_read(7'd70, 32'h70707070);
        issue_read(7'd2,  32'h0);
        step();
        step();

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
